frontpanel_led_refresh: RTL and testbench



---
 rtl/frontpanel_led_refresh_pkg.sv | 45 ++++
 rtl/frontpanel_spi_shifter.sv | 76 +++++++
 rtl/frontpanel_led_refresh.sv | 204 ++++++++++++++++++++
 tb/tb_frontpanel_led_refresh.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frontpanel_led_refresh_pkg.sv
// Shared types and constants for the front-panel LED refresh controller.
// Build option FRONTPANEL_REFRESH_CRC_EN appends a CRC-8 byte to every refresh frame.
package frontpanel_led_refresh_pkg;

  // Controller states. The order is irrelevant; the encoding is never decoded by name elsewhere.
  typedef enum logic [2:0] {
    StIdle,
    StFwOwned,
    StCsSetup,
    StShift,
    StCsHold,
    StGap
  } fp_state_e;

  // Opcode plus four payload bytes.
  localparam int unsigned PAYLOAD_BITS = 40;

  // {relay_state, trig_out_led, trig_in_led}
  localparam int unsigned LED_STATE_BITS = 28;

`ifdef FRONTPANEL_REFRESH_CRC_EN
  localparam int unsigned FRAME_BITS = 48;
`else
  localparam int unsigned FRAME_BITS = 40;
`endif

  localparam logic [7:0] CRC8_POLY = 8'h07;

`ifdef FRONTPANEL_REFRESH_CRC_EN
  // CRC-8, MSB first, init 0, no reflection, no final XOR.
  function automatic logic [7:0] crc8(input logic [PAYLOAD_BITS-1:0] data);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = PAYLOAD_BITS - 1; i >= 0; i--) begin
      if (crc[7] ^ data[i]) begin
        crc = {crc[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        crc = {crc[6:0], 1'b0};
      end
    end
    return crc;
  endfunction
`endif

endpackage

// File: rtl/frontpanel_spi_shifter.sv
// SPI mode-0 frame shifter: parallel load, SCK divider and bit counter.
// load presents the frame MSB on mosi; start begins clocking; done pulses on the
// final SCK falling edge, in the same cycle the shifter returns to idle.
module frontpanel_spi_shifter
  import frontpanel_led_refresh_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame_data,
  input  logic                  start,
  output logic                  done,
  output logic                  sck,
  output logic                  mosi
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(FRAME_BITS);

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shreg_q;
  logic [DivW-1:0]       div_q;
  logic [BitW-1:0]       bit_q;
  logic                  active_q;
  logic                  sck_q;
  logic                  div_last;

  assign div_last = (div_q == DivLast);

  // Last half-period of the last bit, SCK currently high.
  assign done = active_q & div_last & sck_q & (bit_q == BitLast);
  assign sck  = sck_q;
  assign mosi = shreg_q[FRAME_BITS-1];

  // Half-period divider; data advances on each SCK falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      sck_q    <= 1'b0;
    end else if (load) begin
      shreg_q  <= frame_data;
      div_q    <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      sck_q    <= 1'b0;
    end else if (start) begin
      div_q    <= '0;
      bit_q    <= '0;
      active_q <= 1'b1;
      sck_q    <= 1'b0;
    end else if (active_q) begin
      if (div_last) begin
        div_q <= '0;
        sck_q <= ~sck_q;
        if (sck_q) begin
          shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
          if (bit_q == BitLast) begin
            active_q <= 1'b0;
          end else begin
            bit_q <= bit_q + BitW'(1);
          end
        end
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

endmodule

// File: rtl/frontpanel_led_refresh.sv
// Front-panel LED/relay refresh controller.
// Sends the indicator state over the shared front-panel SPI link whenever it changes and on a
// periodic refresh, and hands the pins to the firmware SPI host on request.
// Build option FRONTPANEL_REFRESH_CRC_EN appends a CRC-8 byte to every frame.
module frontpanel_led_refresh
  import frontpanel_led_refresh_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 10,
  parameter int unsigned REFRESH_CYCLES = 25000000,
  parameter logic [7:0]  OPCODE         = 8'h01,
  parameter int unsigned HOLDOFF        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] trig_in_led,
  input  logic [11:0] trig_out_led,
  input  logic [3:0]  relay_state,
  input  logic        fw_req,
  output logic        fw_gnt,
  input  logic        fw_sck,
  input  logic        fw_mosi,
  input  logic        fw_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned TimerW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned CntMax = (CLK_DIV > HOLDOFF) ? CLK_DIV : HOLDOFF;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [TimerW-1:0] TimerMax    = TimerW'(REFRESH_CYCLES - 1);
  localparam logic [CntW-1:0]   DivLast     = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]   HoldoffLast = CntW'(HOLDOFF - 1);

  fp_state_e                 state_q;
  logic [CntW-1:0]           cnt_q;
  logic [TimerW-1:0]         timer_q;
  logic [LED_STATE_BITS-1:0] last_sent_q;
  logic [LED_STATE_BITS-1:0] shadow_q;
  logic                      force_pending_q;
  logic                      fw_block_q;
  logic                      gap_from_fw_q;
  logic                      fw_gnt_q;
  logic                      cs_n_q;
  logic                      busy_q;
  logic [15:0]               frame_count_q;

  logic [LED_STATE_BITS-1:0] cur_state;
  logic [PAYLOAD_BITS-1:0]   payload;
  logic [FRAME_BITS-1:0]     frame_data;
  logic                      pending;
  logic                      fw_wins;
  logic                      frame_load;
  logic                      shift_start;
  logic                      shift_done;
  logic                      shift_sck;
  logic                      shift_mosi;

  assign cur_state = {relay_state, trig_out_led, trig_in_led};

  // Built from the live inputs: the shifter loads it in the same cycle the shadow captures them.
  assign payload = {OPCODE, relay_state, trig_out_led[11:8], trig_out_led[7:0],
                    4'h0, trig_in_led[11:8], trig_in_led[7:0]};

`ifdef FRONTPANEL_REFRESH_CRC_EN
  assign frame_data = {payload, crc8(payload)};
`else
  assign frame_data = payload;
`endif

  assign pending = force_pending_q | (cur_state != last_sent_q) | (timer_q == TimerMax);

  // Right after a firmware session a pending refresh beats an immediate re-request.
  assign fw_wins     = fw_req & ~fw_block_q;
  assign frame_load  = (state_q == StIdle) & ~fw_wins & pending;
  assign shift_start = (state_q == StCsSetup) & (cnt_q == DivLast);

  frontpanel_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (frame_load),
    .frame_data (frame_data),
    .start      (shift_start),
    .done       (shift_done),
    .sck        (shift_sck),
    .mosi       (shift_mosi)
  );

  // Control FSM with registered outputs, refresh timer and change tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      timer_q         <= '0;
      last_sent_q     <= '0;
      shadow_q        <= '0;
      force_pending_q <= 1'b1;
      fw_block_q      <= 1'b0;
      gap_from_fw_q   <= 1'b0;
      fw_gnt_q        <= 1'b0;
      cs_n_q          <= 1'b1;
      busy_q          <= 1'b0;
      frame_count_q   <= '0;
    end else begin
      fw_block_q <= 1'b0;
      if (timer_q != TimerMax) begin
        timer_q <= timer_q + TimerW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (fw_wins) begin
            fw_gnt_q <= 1'b1;
            state_q  <= StFwOwned;
          end else if (pending) begin
            shadow_q        <= cur_state;
            force_pending_q <= 1'b0;
            busy_q          <= 1'b1;
            cs_n_q          <= 1'b0;
            timer_q         <= '0;
            cnt_q           <= '0;
            state_q         <= StCsSetup;
          end
        end

        StFwOwned: begin
          if (!fw_req) begin
            fw_gnt_q      <= 1'b0;
            cs_n_q        <= 1'b1;
            gap_from_fw_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= StGap;
          end
        end

        StCsSetup: begin
          if (cnt_q == DivLast) begin
            cnt_q   <= '0;
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StShift: begin
          if (shift_done) begin
            cnt_q   <= '0;
            state_q <= StCsHold;
          end
        end

        StCsHold: begin
          if (cnt_q == DivLast) begin
            cs_n_q        <= 1'b1;
            busy_q        <= 1'b0;
            last_sent_q   <= shadow_q;
            frame_count_q <= frame_count_q + 16'd1;
            gap_from_fw_q <= 1'b0;
            cnt_q         <= '0;
            state_q       <= StGap;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StGap: begin
          if (cnt_q == HoldoffLast) begin
            fw_block_q <= gap_from_fw_q;
            cnt_q      <= '0;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Pin mux: firmware drives the link with zero latency while granted.
  assign spi_sck     = fw_gnt_q ? fw_sck  : shift_sck;
  assign spi_mosi    = fw_gnt_q ? fw_mosi : shift_mosi;
  assign spi_cs_n    = fw_gnt_q ? fw_cs_n : cs_n_q;
  assign fw_gnt      = fw_gnt_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

  // Firmware must deassert its chip select before releasing the link.
  a_fw_release_cs : assert property (@(posedge clk) disable iff (rst)
    (state_q == StFwOwned && !fw_req) |-> fw_cs_n)
    else $error("fw_req dropped while fw_cs_n low");

  a_gnt_not_busy : assert property (@(posedge clk) disable iff (rst) !(fw_gnt_q && busy_q))
    else $error("fw_gnt asserted during a refresh frame");

endmodule

// File: tb/tb_frontpanel_led_refresh.sv
// Self-checking bench for frontpanel_led_refresh: SPI pin monitor plus a byte-level frame model.
// Define FRONTPANEL_REFRESH_CRC_EN for both RTL and bench to exercise the CRC build.
module tb_frontpanel_led_refresh;

  localparam int unsigned CLK_DIV        = 2;
  localparam int unsigned REFRESH_CYCLES = 1000;
  localparam int unsigned HOLDOFF        = 4;
`ifdef FRONTPANEL_REFRESH_CRC_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif
  localparam int NBITS    = NBYTES * 8;
  localparam int EXP_BUSY = 2 * CLK_DIV + 2 * NBITS * CLK_DIV;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] trig_in_led = '0;
  logic [11:0] trig_out_led = '0;
  logic [3:0]  relay_state = '0;
  logic        fw_req = 1'b0;
  logic        fw_sck = 1'b0;
  logic        fw_mosi = 1'b0;
  logic        fw_cs_n = 1'b1;
  logic        fw_gnt;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic        busy;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Monitor results, one entry per CS_N-low window while not granted.
  logic [63:0] fr_data[$];
  int          fr_bits[$];
  int          fr_start[$];
  int          busy_len[$];
  int          mon_bits = 0;

  frontpanel_led_refresh #(
    .CLK_DIV        (CLK_DIV),
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .OPCODE         (8'h01),
    .HOLDOFF        (HOLDOFF)
  ) dut (
    .clk          (sys_clk),
    .rst          (rst),
    .trig_in_led  (trig_in_led),
    .trig_out_led (trig_out_led),
    .relay_state  (relay_state),
    .fw_req       (fw_req),
    .fw_gnt       (fw_gnt),
    .fw_sck       (fw_sck),
    .fw_mosi      (fw_mosi),
    .fw_cs_n      (fw_cs_n),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .spi_cs_n     (spi_cs_n),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  always #5 sys_clk = ~sys_clk;

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // SPI decoder: samples MOSI on each SCK rise inside a CS_N-low window.
  initial begin
    logic        prev_sck;
    logic        active;
    logic [63:0] data;
    int          start;
    int          brun;
    prev_sck = 1'b0;
    active   = 1'b0;
    data     = '0;
    start    = 0;
    brun     = 0;
    forever begin
      @(negedge sys_clk);
      if (spi_cs_n === 1'b0 && fw_gnt !== 1'b1) begin
        if (!active) begin
          active   = 1'b1;
          mon_bits = 0;
          data     = '0;
          start    = cyc;
        end
        if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
          data = {data[62:0], spi_mosi};
          mon_bits++;
        end
      end else if (active) begin
        active = 1'b0;
        fr_data.push_back(data);
        fr_bits.push_back(mon_bits);
        fr_start.push_back(start);
      end
      if (busy === 1'b1) begin
        brun++;
      end else if (brun != 0) begin
        busy_len.push_back(brun);
        brun = 0;
      end
      prev_sck = spi_sck;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference frame, right-justified, built byte by byte from the input fields.
  function automatic logic [63:0] model_frame(input logic [11:0] tin, input logic [11:0] tout,
                                              input logic [3:0] rel);
    logic [7:0]  b[6];
    logic [7:0]  crc;
    logic [63:0] v;
    b[0] = 8'h01;
    b[1] = {rel, tout[11:8]};
    b[2] = tout[7:0];
    b[3] = {4'h0, tin[11:8]};
    b[4] = tin[7:0];
    crc  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      crc = crc ^ b[i];
      for (int j = 0; j < 8; j++) begin
        crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
      end
    end
    b[5] = crc;
    v = '0;
    for (int i = 0; i < NBYTES; i++) begin
      v = (v << 8) | 64'(b[i]);
    end
    return v;
  endfunction

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic clear_mon();
    fr_data.delete();
    fr_bits.delete();
    fr_start.delete();
    busy_len.delete();
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (fr_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (fr_data.size() >= n);
  endtask

  task automatic wait_cs_low(input int budget, output bit ok);
    int k;
    k = 0;
    while (spi_cs_n !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    ok = (spi_cs_n === 1'b0);
  endtask

  task automatic rand_inputs(output logic [11:0] a, output logic [11:0] b, output logic [3:0] c);
    do begin
      a = 12'($urandom);
      b = 12'($urandom);
      c = 4'($urandom);
    end while (a == trig_in_led && b == trig_out_led && c == relay_state);
  endtask

  task automatic set_inputs(input logic [11:0] a, input logic [11:0] b, input logic [3:0] c);
    trig_in_led  = a;
    trig_out_led = b;
    relay_state  = c;
  endtask

  // Pops one captured frame and compares it with the model for the given inputs.
  task automatic check_next_frame(input string name, input logic [11:0] a, input logic [11:0] b,
                                  input logic [3:0] c);
    logic [63:0] got;
    logic [63:0] exp;
    int          bits;
    got  = fr_data.pop_front();
    bits = fr_bits.pop_front();
    void'(fr_start.pop_front());
    exp  = model_frame(a, b, c);
    n_checks++;
    if (got !== exp || bits != NBITS) begin
      n_errors++;
      $display("FAIL %s: got data %h (%0d bits), required %h (%0d bits)", name, got, bits, exp,
               NBITS);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (fw_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_fw_gnt: got %b required 0", fw_gnt); end
    n_checks++;
    if (spi_sck !== 1'b0) begin n_errors++; $display("FAIL reset_sck: got %b required 0", spi_sck); end
    n_checks++;
    if (spi_mosi !== 1'b0) begin n_errors++; $display("FAIL reset_mosi: got %b required 0", spi_mosi); end
    n_checks++;
    if (spi_cs_n !== 1'b1) begin n_errors++; $display("FAIL reset_cs_n: got %b required 1", spi_cs_n); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++;
    if (frame_count !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_frame_count: got %0d required 0", frame_count);
    end
    clear_mon();
    rst = 1'b0;
  endtask

  task automatic test_first_frame();
    bit ok;
    int blen;
    wait_cs_low(10, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL first_start: cs_n %b after 10 cycles, required 0", spi_cs_n); end
    wait_frames(1, 400, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL first_frame_timeout: got %0d frames required 1", fr_data.size());
    end else begin
      check_next_frame("first_frame", 12'h000, 12'h000, 4'h0);
      blen = (busy_len.size() > 0) ? busy_len.pop_front() : -1;
      n_checks++;
      if (blen != EXP_BUSY) begin
        n_errors++;
        $display("FAIL first_busy_len: got %0d required %0d", blen, EXP_BUSY);
      end
      n_checks++;
      if (frame_count !== 16'd1) begin
        n_errors++;
        $display("FAIL first_frame_count: got %0d required 1", frame_count);
      end
    end
  endtask

  // Returns the start cycle of the change-triggered frame for the refresh test.
  task automatic test_change(output int s);
    bit ok;
    s = cyc;
    set_inputs(12'hA5C, 12'h3F0, 4'h9);
    wait_frames(1, 400, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL change_timeout: got %0d frames required 1", fr_data.size());
    end else begin
      s = fr_start[0];
      check_next_frame("change_frame", 12'hA5C, 12'h3F0, 4'h9);
      void'(busy_len.pop_front());
      while (cyc < s + int'(REFRESH_CYCLES) - 10) tick();
      n_checks++;
      if (fr_data.size() != 0 || spi_cs_n !== 1'b1) begin
        n_errors++;
        $display("FAIL change_quiet: got %0d extra frames, cs_n %b; required 0 frames, cs_n 1",
                 fr_data.size(), spi_cs_n);
      end
    end
  endtask

  task automatic test_refresh(input int s);
    bit ok;
    int prev;
    int st;
    prev = s;
    wait_frames(3, 3400, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL refresh_timeout: got %0d frames required 3", fr_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        st = fr_start[0];
        n_checks++;
        if (st - prev < int'(REFRESH_CYCLES) || st - prev > int'(REFRESH_CYCLES) + 20) begin
          n_errors++;
          $display("FAIL refresh_spacing%0d: got %0d cycles required %0d..%0d", i, st - prev,
                   REFRESH_CYCLES, REFRESH_CYCLES + 20);
        end
        prev = st;
        check_next_frame("refresh_frame", 12'hA5C, 12'h3F0, 4'h9);
      end
    end
    busy_len.delete();
  endtask

  task automatic test_random_changes();
    bit          ok;
    logic [11:0] a;
    logic [11:0] b;
    logic [3:0]  c;
    for (int i = 0; i < 4; i++) begin
      rand_inputs(a, b, c);
      set_inputs(a, b, c);
      wait_frames(1, 600, ok);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL random_timeout%0d: got 0 frames required 1", i);
      end else begin
        check_next_frame("random_frame", a, b, c);
      end
    end
    busy_len.delete();
  endtask

  task automatic test_midframe_change();
    bit          ok;
    logic [11:0] a0, a1, b0, b1;
    logic [3:0]  c0, c1;
    rand_inputs(a0, b0, c0);
    set_inputs(a0, b0, c0);
    wait_cs_low(50, ok);
    repeat (30) tick();
    rand_inputs(a1, b1, c1);
    set_inputs(a1, b1, c1);
    wait_frames(2, 900, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL midframe_timeout: got %0d frames required 2", fr_data.size());
    end else begin
      check_next_frame("midframe_old", a0, b0, c0);
      check_next_frame("midframe_new", a1, b1, c1);
    end
    busy_len.delete();
  endtask

  task automatic test_arbitration();
    bit          ok;
    bit          early;
    int          k;
    logic [11:0] a, b;
    logic [3:0]  c;
    rand_inputs(a, b, c);
    set_inputs(a, b, c);
    wait_cs_low(50, ok);
    repeat (20) tick();
    fw_req  = 1'b1;
    fw_mosi = 1'b1;
    early   = 1'b0;
    k       = 0;
    while (fr_data.size() == 0 && k < 400) begin
      if (fw_gnt !== 1'b0) early = 1'b1;
      tick();
      k++;
    end
    n_checks++;
    if (early || fr_data.size() == 0) begin
      n_errors++;
      $display("FAIL arb_no_grant_in_frame: early grant %b, frames %0d; required 0 and 1", early,
               fr_data.size());
    end
    k = 0;
    while (fw_gnt !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (k < int'(HOLDOFF) + 1 || k > int'(HOLDOFF) + 3) begin
      n_errors++;
      $display("FAIL arb_grant_delay: got %0d cycles after CS_N rise, required %0d..%0d", k,
               HOLDOFF + 1, HOLDOFF + 3);
    end
    n_checks++;
    if (spi_mosi !== 1'b1 || spi_cs_n !== 1'b1 || spi_sck !== 1'b0) begin
      n_errors++;
      $display("FAIL arb_pins_first_cycle: got sck %b mosi %b cs_n %b required 0 1 1", spi_sck,
               spi_mosi, spi_cs_n);
    end
    fw_cs_n = 1'b0;
    fw_sck  = 1'b1;
    fw_mosi = 1'b0;
    #1;
    n_checks++;
    if (spi_cs_n !== 1'b0 || spi_sck !== 1'b1 || spi_mosi !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL arb_pins_follow: got sck %b mosi %b cs_n %b busy %b required 1 0 0 0",
               spi_sck, spi_mosi, spi_cs_n, busy);
    end
    tick();
    fw_sck  = 1'b0;
    fw_cs_n = 1'b1;
    fw_mosi = 1'b0;
    check_next_frame("arb_frame", a, b, c);
    busy_len.delete();
  endtask

  task automatic test_back_to_back();
    bit          early;
    int          k;
    logic [11:0] a, b;
    logic [3:0]  c;
    // Still granted from the previous scenario.
    rand_inputs(a, b, c);
    set_inputs(a, b, c);
    repeat (3) tick();
    fw_req = 1'b0;
    tick();
    n_checks++;
    if (fw_gnt !== 1'b0) begin n_errors++; $display("FAIL b2b_release: got fw_gnt %b required 0", fw_gnt); end
    fw_req = 1'b1;
    early  = 1'b0;
    k      = 0;
    while (fr_data.size() == 0 && k < 500) begin
      if (fw_gnt !== 1'b0) early = 1'b1;
      tick();
      k++;
    end
    n_checks++;
    if (early || fr_data.size() == 0) begin
      n_errors++;
      $display("FAIL b2b_refresh_first: early grant %b, frames %0d; required 0 and 1", early,
               fr_data.size());
    end else begin
      check_next_frame("b2b_frame", a, b, c);
    end
    k = 0;
    while (fw_gnt !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (fw_gnt !== 1'b1) begin n_errors++; $display("FAIL b2b_regrant: got fw_gnt %b required 1", fw_gnt); end
    fw_req = 1'b0;
    repeat (HOLDOFF + 2) tick();
    busy_len.delete();
  endtask

  task automatic test_reset_midshift();
    bit          ok;
    int          k;
    logic [11:0] a, b;
    logic [3:0]  c;
    rand_inputs(a, b, c);
    set_inputs(a, b, c);
    wait_cs_low(50, ok);
    k = 0;
    while (mon_bits < 17 && k < 200) begin
      tick();
      k++;
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (spi_cs_n !== 1'b1 || spi_sck !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_pins: got cs_n %b sck %b busy %b required 1 0 0", spi_cs_n, spi_sck,
               busy);
    end
    n_checks++;
    if (frame_count !== 16'd0) begin
      n_errors++;
      $display("FAIL midreset_count: got %0d required 0", frame_count);
    end
    tick();
    clear_mon();
    rst = 1'b0;
    wait_frames(1, 400, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL midreset_timeout: got 0 frames required 1");
    end else begin
      check_next_frame("midreset_frame", a, b, c);
      n_checks++;
      if (frame_count !== 16'd1) begin
        n_errors++;
        $display("FAIL midreset_count_after: got %0d required 1", frame_count);
      end
    end
  endtask

  initial begin
    int s;
    test_reset();
    test_first_frame();
    test_change(s);
    test_refresh(s);
    test_random_changes();
    test_midframe_change();
    test_arbitration();
    test_back_to_back();
    test_reset_midshift();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
